// File: rtl/seq_det_param.sv
// Parametrised Moore sequence detector with a run-time loadable pattern and per-cycle overlap control.
// Optional saturating match counter and match_cnt port when SEQ_DET_COUNT_EN is defined.
module seq_det_param #(
   parameter int unsigned        PAT_W       = 4,
   parameter logic [PAT_W-1:0]   PAT_DEFAULT = 4'b1011,
   parameter int unsigned        CNT_W       = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              x,
   input  logic              ovr_mode,
   input  logic              pat_ld,
   input  logic [PAT_W-1:0]  pat_in,
   output logic [PAT_W-1:0]  pat,
   output logic              z
`ifdef SEQ_DET_COUNT_EN
   ,
   output logic [CNT_W-1:0]  match_cnt
`endif
);

   localparam int unsigned       FILL_W    = $clog2(PAT_W + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
   localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);

   typedef enum logic [0:0] {
      S_SEARCH = 1'b0,
      S_MATCH  = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [PAT_W-1:0]   pat_q, pat_d;
   logic [PAT_W-1:0]   hist_q, hist_d;
   logic [FILL_W-1:0]  fill_q, fill_d;
   logic [PAT_W-1:0]   hist_n;
   logic [FILL_W-1:0]  fill_n;
   logic               hit;

   // Candidate history/fill for an accepted sample and the resulting match decision
   always_comb begin
      hist_n = {hist_q[PAT_W-2:0], x};
      if (fill_q == FILL_FULL) begin
         fill_n = FILL_FULL;
      end else begin
         fill_n = fill_q + FILL_ONE;
      end
      hit = (fill_n == FILL_FULL) && (hist_n == pat_q);
   end

   // Next-state: pattern load beats sampling; a non-overlap hit forces PAT_W fresh bits
   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      hist_d  = hist_q;
      fill_d  = fill_q;
      if (pat_ld) begin
         state_d = S_SEARCH;
         pat_d   = pat_in;
         hist_d  = '0;
         fill_d  = '0;
      end else if (en) begin
         hist_d = hist_n;
         if (hit) begin
            state_d = S_MATCH;
         end else begin
            state_d = S_SEARCH;
         end
         if (hit && !ovr_mode) begin
            fill_d = '0;
         end else begin
            fill_d = fill_n;
         end
      end else begin
         state_d = state_q;
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_SEARCH;
         pat_q   <= PAT_DEFAULT;
         hist_q  <= '0;
         fill_q  <= '0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         hist_q  <= hist_d;
         fill_q  <= fill_d;
      end
   end

   assign pat = pat_q;
   assign z   = (state_q == S_MATCH);

`ifdef SEQ_DET_COUNT_EN
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Saturating count of accepted hits, cleared on pattern load
   always_comb begin
      cnt_d = cnt_q;
      if (pat_ld) begin
         cnt_d = '0;
      end else if (en && hit && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_ONE;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Match counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign match_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_seq_det_param.sv
// Self-checking bench for seq_det_param: directed test-plan scenarios plus randomized traffic
// against a queue-based reference model of accepted bits.
module tb_seq_det_param;

   localparam int PW = 4;

   logic          clk;
   logic          rst;
   logic          en;
   logic          x;
   logic          ovr_mode;
   logic          pat_ld;
   logic [PW-1:0] pat_in;
   logic [PW-1:0] pat;
   logic          z;
   logic [1:0]    pat2;
   logic          z2;
`ifdef SEQ_DET_COUNT_EN
   logic [7:0]    match_cnt;
   logic [1:0]    match_cnt2;
`endif

   int errors = 0;
   int checks = 0;

   // reference model state
   bit            m_q[$];
   logic [PW-1:0] m_pat;
   logic          m_z;
   int            m_cnt;

   seq_det_param #(.PAT_W(4), .PAT_DEFAULT(4'b1011), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .en(en), .x(x), .ovr_mode(ovr_mode),
      .pat_ld(pat_ld), .pat_in(pat_in), .pat(pat), .z(z)
`ifdef SEQ_DET_COUNT_EN
      , .match_cnt(match_cnt)
`endif
   );

   seq_det_param #(.PAT_W(2), .PAT_DEFAULT(2'b11), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .en(en), .x(x), .ovr_mode(ovr_mode),
      .pat_ld(pat_ld), .pat_in(2'b11), .pat(pat2), .z(z2)
`ifdef SEQ_DET_COUNT_EN
      , .match_cnt(match_cnt2)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // apply one cycle of inputs, advance the model, sample #1 after the edge
   task automatic cycle(input logic i_rst, input logic i_en, input logic i_x,
                        input logic i_ovr, input logic i_ld, input logic [PW-1:0] i_pat);
      logic [PW-1:0] v;
      logic hit;
      rst = i_rst; en = i_en; x = i_x; ovr_mode = i_ovr; pat_ld = i_ld; pat_in = i_pat;
      @(posedge clk);
      if (i_rst) begin
         m_pat = 4'b1011; m_q.delete(); m_z = 1'b0; m_cnt = 0;
      end else if (i_ld) begin
         m_pat = i_pat; m_q.delete(); m_z = 1'b0; m_cnt = 0;
      end else if (i_en) begin
         m_q.push_back(i_x);
         if (m_q.size() > PW) void'(m_q.pop_front());
         v = '0;
         foreach (m_q[i]) v = {v[PW-2:0], m_q[i]};
         hit = (m_q.size() == PW) && (v == m_pat);
         m_z = hit;
         if (hit && m_cnt < 255) m_cnt++;
         if (hit && !i_ovr) m_q.delete();
      end
      #1;
   endtask

   task automatic test_reset();
      cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0110);
      checks++;
      if (z !== 1'b0) begin errors++; $display("FAIL reset_z got=%b exp=0", z); end
      checks++;
      if (pat !== 4'b1011) begin errors++; $display("FAIL reset_pat got=%b exp=1011", pat); end
      checks++;
      if (z2 !== 1'b0 || pat2 !== 2'b11) begin errors++; $display("FAIL reset_dut2 got z=%b pat=%b exp z=0 pat=11", z2, pat2); end
`ifdef SEQ_DET_COUNT_EN
      checks++;
      if (match_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", match_cnt); end
`endif
   endtask

   task automatic run_stream(input logic ovr, input logic [11:0] exp_z, input string name);
      logic [11:0] bits;
      bits = 12'b1011_0110_1101;
      cycle(1'b1, 1'b0, 1'b0, ovr, 1'b0, 4'b0000);
      for (int i = 0; i < 12; i++) begin
         cycle(1'b0, 1'b1, bits[11-i], ovr, 1'b0, 4'b0000);
         checks++;
         if (z !== exp_z[11-i] || z !== m_z)
            begin errors++; $display("FAIL %s_z bit%0d got=%b exp=%b model=%b", name, i+1, z, exp_z[11-i], m_z); end
      end
   endtask

   task automatic test_overlap();
      run_stream(1'b1, 12'b0001_0010_0100, "ovl");
`ifdef SEQ_DET_COUNT_EN
      checks++;
      if (match_cnt !== 8'd3) begin errors++; $display("FAIL ovl_cnt got=%0d exp=3", match_cnt); end
`endif
   endtask

   task automatic test_nonoverlap();
      run_stream(1'b0, 12'b0001_0000_0100, "novl");
`ifdef SEQ_DET_COUNT_EN
      checks++;
      if (match_cnt !== 8'd2) begin errors++; $display("FAIL novl_cnt got=%0d exp=2", match_cnt); end
`endif
   endtask

   task automatic test_gap();
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
      cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000);
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, 1'b0, i[0], 1'b1, 1'b0, 4'b0000);
         checks++;
         if (z !== 1'b0) begin errors++; $display("FAIL gap_hold0 c%0d got=%b exp=0", i, z); end
      end
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
      checks++;
      if (z !== 1'b1 || m_z !== 1'b1) begin errors++; $display("FAIL gap_hit got=%b exp=1", z); end
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b0, ~i[0], 1'b1, 1'b0, 4'b0000);
         checks++;
         if (z !== 1'b1) begin errors++; $display("FAIL gap_hold1 c%0d got=%b exp=1", i, z); end
      end
   endtask

   task automatic test_pat_load();
      logic [5:0] exp_z;
      exp_z = 6'b000111;
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1111);
      checks++;
      if (pat !== 4'b1111 || z !== 1'b0) begin errors++; $display("FAIL ld_state got pat=%b z=%b exp pat=1111 z=0", pat, z); end
`ifdef SEQ_DET_COUNT_EN
      checks++;
      if (match_cnt !== 8'd0) begin errors++; $display("FAIL ld_cnt got=%0d exp=0", match_cnt); end
`endif
      for (int i = 0; i < 6; i++) begin
         cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
         checks++;
         if (z !== exp_z[5-i] || z !== m_z) begin errors++; $display("FAIL ld_ones_z one%0d got=%b exp=%b", i+1, z, exp_z[5-i]); end
      end
`ifdef SEQ_DET_COUNT_EN
      checks++;
      if (match_cnt !== 8'd3) begin errors++; $display("FAIL ld_ones_cnt got=%0d exp=3", match_cnt); end
`endif
   endtask

   task automatic test_reset_midstream();
      logic [3:0] bits;
      logic [3:0] exp_z;
      bits = 4'b1011; exp_z = 4'b0001;
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
      cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000);
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
      cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 1'b1, bits[3-i], 1'b1, 1'b0, 4'b0000);
         checks++;
         if (z !== exp_z[3-i]) begin errors++; $display("FAIL rst_mid_z bit%0d got=%b exp=%b", i, z, exp_z[3-i]); end
      end
   endtask

   task automatic test_saturation();
      logic [7:0] exp_z;
      exp_z = 8'b0111_1111;
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
      for (int i = 0; i < 8; i++) begin
         cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
         checks++;
         if (z2 !== exp_z[7-i]) begin errors++; $display("FAIL sat_z one%0d got=%b exp=%b", i+1, z2, exp_z[7-i]); end
`ifdef SEQ_DET_COUNT_EN
         checks++;
         if (match_cnt2 !== 2'((i > 3) ? 3 : i))
            begin errors++; $display("FAIL sat_cnt one%0d got=%0d exp=%0d", i+1, match_cnt2, (i > 3) ? 3 : i); end
`endif
      end
   endtask

   task automatic test_random();
      int r;
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
      for (int i = 0; i < 500; i++) begin
         r = $urandom_range(0, 99);
         cycle(r < 2, ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
               (r >= 2 && r < 6), 4'($urandom));
         checks++;
         if (z !== m_z || pat !== m_pat)
            begin errors++; $display("FAIL rand c%0d got z=%b pat=%b exp z=%b pat=%b", i, z, pat, m_z, m_pat); end
`ifdef SEQ_DET_COUNT_EN
         checks++;
         if (match_cnt !== 8'(m_cnt)) begin errors++; $display("FAIL rand_cnt c%0d got=%0d exp=%0d", i, match_cnt, m_cnt); end
`endif
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; x = 1'b0; ovr_mode = 1'b1; pat_ld = 1'b0; pat_in = '0;
      m_pat = 4'b1011; m_z = 1'b0; m_cnt = 0;
      test_reset();
      test_overlap();
      test_nonoverlap();
      test_gap();
      test_pat_load();
      test_reset_midstream();
      test_saturation();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seq_det_param.md
Name: seq_det_param

Overview:
- Parametrised Moore sequence detector. Successor to the fixed 4-bit overlapping detector.
- Serial bit `x`, qualified by `en`, is compared against a PAT_W-bit pattern. The pattern is loadable at run time and resets to PAT_DEFAULT.
- Overlapping or non-overlapping detection is selected per cycle by `ovr_mode`.
- Used by bit-stream framing logic as a configurable sync/marker detector.

Parameters:
- PAT_W, 4, pattern length in bits. Legal range 2..32.
- PAT_DEFAULT, 4'b1011, pattern loaded at reset. MSB is the oldest bit.
- CNT_W, 8, width of the optional match counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  sample qualifier. `x` is consumed only when en=1.
- x  input  1  serial data bit.
- ovr_mode  input  1  1 = overlapping detection, 0 = non-overlapping.
- pat_ld  input  1  load `pat_in` as the new pattern and restart detection.
- pat_in  input  PAT_W  new pattern. MSB is the oldest bit.
- pat  output  PAT_W  currently active pattern register.
- z  output  1  Moore match output, registered.
- match_cnt  output  CNT_W  match event count. Present only with SEQ_DET_COUNT_EN.

Behaviour:
- Reset (rst=1 at a clk edge):
  - pat <= PAT_DEFAULT
  - hist <= 0, fill <= 0
  - z <= 0, match_cnt <= 0
  - rst overrides all other inputs.
- State:
  - `hist[PAT_W-1:0]` is a shift history of accepted bits.
  - `fill` counts valid history bits, range 0..PAT_W, saturating at PAT_W.
  - z is the Moore state bit MATCH. It is driven only by registers, never combinationally by `x`.
- Accepted sample (en=1, pat_ld=0, rst=0):
  - hist_n = {hist[PAT_W-2:0], x}
  - fill_n = min(fill+1, PAT_W)
  - hit = (fill_n == PAT_W) && (hist_n == pat)
  - hist <= hist_n, z <= hit
  - If hit and ovr_mode=0: fill <= 0, so the next match needs PAT_W fresh bits.
  - Otherwise: fill <= fill_n.
- Latency: x sampled at edge k completes a match, so z=1 from edge k until the next state change (one cycle at full rate).
- en=0: hist, fill and z all hold. z stays high if the last accepted sample was a hit (Moore hold).
- pat_ld=1 (rst=0):
  - pat <= pat_in; fill <= 0; z <= 0; hist <= 0.
  - Any simultaneous x is discarded; pat_ld takes priority over en.
  - match_cnt <= 0.
- ovr_mode changes take effect on the next accepted sample. No flush occurs.
- z never asserts before PAT_W bits have been accepted since reset, pat_ld, or a non-overlap match.
- Back-to-back hits in overlap mode (e.g. an all-ones pattern fed with ones) keep z=1 continuously.
- Reset asserted mid-stream discards partial history. Detection restarts from fill=0 on the cycle after rst deasserts.

Optional Feature:
- Macro SEQ_DET_COUNT_EN.
- Defined:
  - `match_cnt` port exists.
  - Increments by 1 on every accepted sample with hit=1, including consecutive overlap hits.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Cleared by rst and by pat_ld.
- Undefined: port and counter logic are absent. All other behaviour is identical.

Test Plan:
- Reset then default pattern 1011, ovr_mode=1, en=1, stream 1,0,1,1,0,1,1,0,1,1,0,1 -> z=1 for one cycle after bits 4, 7 and 10 only; match_cnt=3.
- Same stream with ovr_mode=0 -> z=1 after bits 4 and 10 only; after bit 7, z=0; match_cnt=2.
- Gap test: stream 1,0,1 with en=1, then 5 cycles en=0 with x toggling, then en=1 with x=1 -> z=1 after the final accepted bit; z held 0 during the gap. Next en=0 cycles hold z=1.
- pat_ld with pat_in=4'b1111 and en=1, x=1 in the same cycle -> x ignored, pat=1111, z=0, match_cnt=0. Then 6 ones at ovr_mode=1 -> z=1 after the 4th, 5th and 6th (continuously high); match_cnt=3.
- Reset mid-stream: after bits 1,0,1, assert rst one cycle, then send 1 -> z stays 0. Then send 0,1,1 -> z=1 only after the final 1.
- Saturation (CNT_W=2, SEQ_DET_COUNT_EN defined): pattern 11, ovr_mode=1, 8 ones -> match_cnt reaches 3 and stays 3. Rebuild without the macro: z sequence unchanged.
